rsign_ctrl: RTL
===============

Name: rsign_ctrl

Overview:
Sequencer for the per-channel RSign binarisation stage. It loads FM_DEPTH signed 16-bit thresholds from a serial parameter stream into a local bank, then drives the stage's mode and valid inputs for one frame of NUM_WIN windows. It also counts the stage's output valids to signal frame completion. It sits between the layer scheduler / parameter DMA and the RSign datapath.

Parameters:
FM_DEPTH, 64, number of channels = number of threshold words per load
NUM_WIN, 3136, windows per frame (56x56)
CNT_W, $clog2(NUM_WIN+1), width of window counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
load_start  in  1  pulse: begin threshold load
run_start  in  1  pulse: begin one frame
abort  in  1  pulse: return to IDLE from any state
para_valid  in  1  threshold word valid
para_data  in  16  signed threshold word, channel order 0..FM_DEPTH-1
para_ready  out  1  controller accepts threshold word
win_valid_in  in  1  upstream window valid
win_ready  out  1  controller accepts window
mode_out  out  1  to datapath mode input; 0 = load/idle, 1 = calculate
data_valid_out  out  1  to datapath data-valid input
para_out  out  FM_DEPTH*16  threshold bank, channel i at bits [16*i+15:16*i]
rsign_valid_in  in  1  datapath output-valid
params_loaded  out  1  bank holds a complete threshold set
load_done  out  1  1-cycle pulse, load complete
frame_done  out  1  1-cycle pulse, all NUM_WIN outputs observed
busy  out  1  state != IDLE
err  out  1  1-cycle pulse on protocol violation

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bank all 0; ptr, win_cnt, out_cnt = 0; all outputs 0.
- States: IDLE, LOAD, RUN, DRAIN. abort in any state -> IDLE next cycle, counters cleared; bank and params_loaded kept, except abort during LOAD clears params_loaded; no done pulses.
- IDLE transitions:
  - load_start -> LOAD; ptr=0; params_loaded=0.
  - run_start with params_loaded=1 -> RUN; win_cnt=out_cnt=0.
  - run_start with params_loaded=0 -> err pulse; stay IDLE.
  - load_start and run_start in the same cycle -> load wins; run_start is dropped without err.
- LOAD: para_ready=1 (registered, asserted from the first LOAD cycle).
  - On para_valid&&para_ready: bank[ptr]<=para_data, ptr++.
  - Acceptance at ptr==FM_DEPTH-1 -> IDLE; params_loaded=1 and load_done=1 in the following cycle.
  - para_valid outside LOAD is ignored.
- RUN: mode_out=1; win_ready=1; data_valid_out = win_valid_in (combinational, RUN only).
  - Each accepted window: win_cnt++.
  - The accept taking win_cnt to NUM_WIN -> DRAIN; win_ready=0 from the next cycle.
- DRAIN: mode_out=1, win_ready=0, data_valid_out=0.
- Output counting: out_cnt++ on rsign_valid_in in RUN or DRAIN. When out_cnt reaches NUM_WIN in DRAIN -> frame_done pulse and IDLE in the same cycle edge; mode_out returns to 0.
- Bank stability: para_out changes only in LOAD and is stable throughout RUN/DRAIN.
- Error pulses:
  - load_start or run_start in LOAD/RUN/DRAIN -> err pulse, request ignored.
  - rsign_valid_in in IDLE or LOAD -> err pulse, no count.
  - rsign_valid_in in DRAIN after out_cnt==NUM_WIN cannot occur, since the state has already left DRAIN.
- busy = (state!=IDLE).
- Counters are unsigned CNT_W bits, compared for equality and never wrap within a frame.

Test Plan:
- Load: load_start, then 64 words 0x0000..0x003F with para_valid gaps every 3rd cycle -> para_out[16*i+:16]==i; load_done pulses exactly once, 1 cycle after the 64th accept; params_loaded=1.
- Run without params: after reset, run_start -> err=1 for one cycle; state stays IDLE; mode_out=0.
- Frame (NUM_WIN=8 override): load, run_start, 8 win_valid_in with bubbles, rsign_valid_in echoed 1 cycle later -> data_valid_out count 8, win_ready drops after the 8th, frame_done on the 8th rsign_valid_in, mode_out=0 afterward.
- Collisions: load_start+run_start in the same IDLE cycle -> LOAD, no err. load_start during RUN -> err pulse, bank unchanged, frame still completes.
- Abort: abort after 30 of 64 words -> IDLE, params_loaded=0, no load_done. Abort mid-RUN -> IDLE, no frame_done, params_loaded still 1.
- Async reset mid-RUN: rst_n low between clock edges -> all outputs 0 immediately, bank zeroed; after release, run_start gives err.

Source files
------------

// File: rtl/rsign_ctrl.sv
// Sequencer for the RSign binarisation stage: loads the per-channel threshold bank,
// then gates one frame of windows into the datapath and counts its outputs back.
module rsign_ctrl #(
    parameter int FM_DEPTH = 64,
    parameter int NUM_WIN  = 3136,
    parameter int CNT_W    = $clog2(NUM_WIN + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_load_start,
    input  logic                     i_run_start,
    input  logic                     i_abort,
    input  logic                     i_para_valid,
    input  logic [15:0]              i_para_data,
    output logic                     o_para_ready,
    input  logic                     i_win_valid_in,
    output logic                     o_win_ready,
    output logic                     o_mode_out,
    output logic                     o_data_valid_out,
    output logic [FM_DEPTH*16-1:0]   o_para_out,
    input  logic                     i_rsign_valid_in,
    output logic                     o_params_loaded,
    output logic                     o_load_done,
    output logic                     o_frame_done,
    output logic                     o_busy,
    output logic                     o_err
);

    localparam int PTR_W = (FM_DEPTH > 1) ? $clog2(FM_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                    r_state, w_state_nxt;
    logic [PTR_W-1:0]          r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0]          r_win_cnt, w_win_cnt_nxt;
    logic [CNT_W-1:0]          r_out_cnt, w_out_cnt_nxt;
    logic                      r_params_loaded, w_params_loaded_nxt;
    logic                      r_load_done, w_load_done_nxt;
    logic                      r_frame_done, w_frame_done_nxt;
    logic                      r_err, w_err_nxt;
    logic [FM_DEPTH-1:0][15:0] r_bank;

    logic w_para_acc;
    logic w_win_acc;
    logic w_last_word;
    logic w_last_win;
    logic w_last_out;
    logic w_start_req;

    // Handshake outputs decode straight from the state register, so they are
    // glitch-free and drop to 0 the instant reset asserts.
    assign o_para_ready     = (r_state == S_LOAD);
    assign o_win_ready      = (r_state == S_RUN);
    assign o_mode_out       = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign o_data_valid_out = (r_state == S_RUN) && i_win_valid_in;
    assign o_busy           = (r_state != S_IDLE);
    assign o_para_out       = r_bank;
    assign o_params_loaded  = r_params_loaded;
    assign o_load_done      = r_load_done;
    assign o_frame_done     = r_frame_done;
    assign o_err            = r_err;

    assign w_para_acc  = o_para_ready && i_para_valid;
    assign w_win_acc   = o_win_ready && i_win_valid_in;
    assign w_last_word = (r_ptr == PTR_W'(FM_DEPTH - 1));
    assign w_last_win  = (r_win_cnt == CNT_W'(NUM_WIN - 1));
    assign w_last_out  = (r_out_cnt == CNT_W'(NUM_WIN - 1));
    assign w_start_req = i_load_start || i_run_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_ptr           <= '0;
            r_win_cnt       <= '0;
            r_out_cnt       <= '0;
            r_params_loaded <= 1'b0;
            r_load_done     <= 1'b0;
            r_frame_done    <= 1'b0;
            r_err           <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ptr           <= w_ptr_nxt;
            r_win_cnt       <= w_win_cnt_nxt;
            r_out_cnt       <= w_out_cnt_nxt;
            r_params_loaded <= w_params_loaded_nxt;
            r_load_done     <= w_load_done_nxt;
            r_frame_done    <= w_frame_done_nxt;
            r_err           <= w_err_nxt;
        end
    end

    // Bank only writes on a LOAD handshake, so it is frozen across RUN/DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bank <= '0;
        end else if (w_para_acc) begin
            for (int i = 0; i < FM_DEPTH; i++) begin
                if (r_ptr == PTR_W'(i)) r_bank[i] <= i_para_data;
            end
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        w_ptr_nxt           = r_ptr;
        w_win_cnt_nxt       = r_win_cnt;
        w_out_cnt_nxt       = r_out_cnt;
        w_params_loaded_nxt = r_params_loaded;
        w_load_done_nxt     = 1'b0;
        w_frame_done_nxt    = 1'b0;
        w_err_nxt           = 1'b0;

        if (i_abort) begin
            w_state_nxt   = S_IDLE;
            w_ptr_nxt     = '0;
            w_win_cnt_nxt = '0;
            w_out_cnt_nxt = '0;
            if (r_state == S_LOAD) w_params_loaded_nxt = 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_rsign_valid_in) w_err_nxt = 1'b1;
                    // A simultaneous run_start is silently dropped in favour of the load.
                    if (i_load_start) begin
                        w_state_nxt         = S_LOAD;
                        w_ptr_nxt           = '0;
                        w_params_loaded_nxt = 1'b0;
                    end else if (i_run_start) begin
                        if (r_params_loaded) begin
                            w_state_nxt   = S_RUN;
                            w_win_cnt_nxt = '0;
                            w_out_cnt_nxt = '0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_start_req || i_rsign_valid_in) w_err_nxt = 1'b1;
                    if (w_para_acc) begin
                        w_ptr_nxt = r_ptr + PTR_W'(1);
                        if (w_last_word) begin
                            w_state_nxt         = S_IDLE;
                            w_ptr_nxt           = '0;
                            w_params_loaded_nxt = 1'b1;
                            w_load_done_nxt     = 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_start_req) w_err_nxt = 1'b1;
                    if (i_rsign_valid_in) w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
                    if (w_win_acc) begin
                        w_win_cnt_nxt = r_win_cnt + CNT_W'(1);
                        if (w_last_win) w_state_nxt = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_start_req) w_err_nxt = 1'b1;
                    if (i_rsign_valid_in) begin
                        w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
                        if (w_last_out) begin
                            w_state_nxt      = S_IDLE;
                            w_frame_done_nxt = 1'b1;
                            w_win_cnt_nxt    = '0;
                            w_out_cnt_nxt    = '0;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule
